// File: rtl/bin_bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The master drives the operand and start; the slave returns status and digits.
interface bin_bcd_seq_if #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  signed_en;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  sign;
    logic                  overflow;
    logic [DIGITS-1:0]     nz_mask;

    modport master (
        output start, bin, signed_en,
        input  busy, done, bcd, sign, overflow, nz_mask
    );

    modport slave (
        input  start, bin, signed_en,
        output busy, done, bcd, sign, overflow, nz_mask
    );
endinterface

// File: rtl/bin_bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle through a shared bank of
// per-digit +3 correctors, with sign handling, overflow detection and blanking mask.
module bin_bcd_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    bin_bcd_seq_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  mag_q, mag_d;
    logic [BW-1:0]     bcd_sh_q, bcd_sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sen_q, sen_d;
    logic              neg_q, neg_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              sign_q, sign_d;
    logic              overflow_q, overflow_d;
    logic [DIGITS-1:0] nz_q, nz_d;

    logic [BW-1:0]     corr;
    logic [DIGITS-1:0] nz_calc;

    // One corrector per digit, reused on every shift cycle.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign corr[4*gi +: 4] = (bcd_sh_q[4*gi +: 4] >= 4'd5) ?
                                     bcd_sh_q[4*gi +: 4] + 4'd3 : bcd_sh_q[4*gi +: 4];
            if (gi == 0) begin : g_ones
                assign nz_calc[gi] = 1'b1;
            end else begin : g_upper
                assign nz_calc[gi] = |bcd_sh_q[BW-1:4*gi];
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        bcd_sh_d   = bcd_sh_q;
        cnt_d      = cnt_q;
        sen_d      = sen_q;
        neg_d      = neg_q;
        ovf_acc_d  = ovf_acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        overflow_d = overflow_q;
        nz_d       = nz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mag_d   = bus.bin;
                    sen_d   = bus.signed_en;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Negating the most negative value wraps to itself, which read
                // as unsigned is exactly its magnitude.
                neg_d     = sen_q & mag_q[BIN_W-1];
                mag_d     = (sen_q & mag_q[BIN_W-1]) ? -mag_q : mag_q;
                bcd_sh_d  = '0;
                cnt_d     = '0;
                ovf_acc_d = 1'b0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                bcd_sh_d  = {corr[BW-2:0], mag_q[BIN_W-1]};
                mag_d     = {mag_q[BIN_W-2:0], 1'b0};
                ovf_acc_d = ovf_acc_q | corr[BW-1];
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(BIN_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d      = bcd_sh_q;
                sign_d     = neg_q;
                overflow_d = ovf_acc_q;
                nz_d       = nz_calc;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            bcd_sh_q   <= '0;
            cnt_q      <= '0;
            sen_q      <= 1'b0;
            neg_q      <= 1'b0;
            ovf_acc_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            overflow_q <= 1'b0;
            nz_q       <= DIGITS'(1);
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            bcd_sh_q   <= bcd_sh_d;
            cnt_q      <= cnt_d;
            sen_q      <= sen_d;
            neg_q      <= neg_d;
            ovf_acc_q  <= ovf_acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            overflow_q <= overflow_d;
            nz_q       <= nz_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.sign     = sign_q;
    assign bus.overflow = overflow_q;
    assign bus.nz_mask  = nz_q;
endmodule

// File: tb/tb_bin_bcd_seq.sv
// Directed bench for bin_bcd_seq: a 10-digit and a 9-digit instance share one stimulus.
module tb_bin_bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bin_v = '0;
    logic        sen = 1'b0;
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    bin_bcd_seq_if #(.BIN_W(32), .DIGITS(10)) bus10 ();
    bin_bcd_seq_if #(.BIN_W(32), .DIGITS(9))  bus9 ();

    assign bus10.start = start;
    assign bus10.bin = bin_v;
    assign bus10.signed_en = sen;
    assign bus9.start = start;
    assign bus9.bin = bin_v;
    assign bus9.signed_en = sen;

    bin_bcd_seq #(.BIN_W(32), .DIGITS(10)) dut10 (.clk(clk), .rst_n(rst), .bus(bus10));
    bin_bcd_seq #(.BIN_W(32), .DIGITS(9))  dut9  (.clk(clk), .rst_n(rst), .bus(bus9));

    // Starts one conversion and returns edges from accept to done, or -1 on timeout.
    task automatic do_conv(input logic [31:0] b, input logic s, output int lat);
        @(negedge clk);
        start = 1'b1; bin_v = b; sen = s;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            if (bus10.done) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; bin_v = 32'd77;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus10.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus10.busy); end
        vectors++; if (bus10.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus10.done); end
        vectors++; if (bus10.bcd !== 40'h0) begin errors++; $display("FAIL reset_bcd got %h want 0", bus10.bcd); end
        vectors++; if ({bus10.sign, bus10.overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {bus10.sign, bus10.overflow}); end
        vectors++; if (bus10.nz_mask !== 10'h001) begin errors++; $display("FAIL reset_nz got %h want 001", bus10.nz_mask); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bus10.busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored busy got %b want 0", bus10.busy); end
        $display("test_reset done");
    endtask

    task automatic test_unsigned_max();
        int lat;
        do_conv(32'hFFFF_FFFF, 1'b0, lat);
        vectors++; if (lat !== 34) begin errors++; $display("FAIL umax_latency got %0d want 34", lat); end
        vectors++; if (bus10.bcd !== 40'h4294967295) begin errors++; $display("FAIL umax_bcd got %h want 4294967295", bus10.bcd); end
        vectors++; if ({bus10.sign, bus10.overflow} !== 2'b00) begin errors++; $display("FAIL umax_flags got %b want 00", {bus10.sign, bus10.overflow}); end
        vectors++; if (bus10.nz_mask !== 10'h3FF) begin errors++; $display("FAIL umax_nz got %h want 3ff", bus10.nz_mask); end
        vectors++; if (bus9.done !== 1'b1) begin errors++; $display("FAIL umax9_done got %b want 1", bus9.done); end
        vectors++; if (bus9.bcd !== 36'h294967295) begin errors++; $display("FAIL umax9_bcd got %h want 294967295", bus9.bcd); end
        vectors++; if (bus9.overflow !== 1'b1) begin errors++; $display("FAIL umax9_ovf got %b want 1", bus9.overflow); end
        $display("test_unsigned_max bin=ffffffff bcd=%h bcd9=%h lat=%0d", bus10.bcd, bus9.bcd, lat);
    endtask

    task automatic test_signed();
        int lat;
        do_conv(32'hFFFF_FFFF, 1'b1, lat);
        vectors++; if (bus10.bcd !== 40'h1) begin errors++; $display("FAIL sneg1_bcd got %h want 1", bus10.bcd); end
        vectors++; if (bus10.sign !== 1'b1) begin errors++; $display("FAIL sneg1_sign got %b want 1", bus10.sign); end
        vectors++; if (bus10.nz_mask !== 10'h001) begin errors++; $display("FAIL sneg1_nz got %h want 001", bus10.nz_mask); end
        $display("test_signed bin=ffffffff bcd=%h sign=%b", bus10.bcd, bus10.sign);
        do_conv(32'h8000_0000, 1'b1, lat);
        vectors++; if (bus10.bcd !== 40'h2147483648) begin errors++; $display("FAIL smin_bcd got %h want 2147483648", bus10.bcd); end
        vectors++; if ({bus10.sign, bus10.overflow} !== 2'b10) begin errors++; $display("FAIL smin_flags got %b want 10", {bus10.sign, bus10.overflow}); end
        vectors++; if (bus10.nz_mask !== 10'h3FF) begin errors++; $display("FAIL smin_nz got %h want 3ff", bus10.nz_mask); end
        $display("test_signed bin=80000000 bcd=%h sign=%b", bus10.bcd, bus10.sign);
        do_conv(32'h8000_0000, 1'b0, lat);
        vectors++; if ({bus10.sign, bus10.bcd} !== {1'b0, 40'h2147483648}) begin errors++; $display("FAIL uhalf got sign=%b bcd=%h want sign=0 bcd=2147483648", bus10.sign, bus10.bcd); end
        $display("test_signed unsigned bin=80000000 bcd=%h sign=%b", bus10.bcd, bus10.sign);
    endtask

    task automatic test_zero();
        int lat;
        for (int m = 0; m < 2; m++) begin
            do_conv(32'h0, m[0], lat);
            vectors++; if (bus10.bcd !== 40'h0) begin errors++; $display("FAIL zero_bcd mode=%0d got %h want 0", m, bus10.bcd); end
            vectors++; if ({bus10.sign, bus10.overflow} !== 2'b00) begin errors++; $display("FAIL zero_flags mode=%0d got %b want 00", m, {bus10.sign, bus10.overflow}); end
            vectors++; if (bus10.nz_mask !== 10'h001) begin errors++; $display("FAIL zero_nz mode=%0d got %h want 001", m, bus10.nz_mask); end
            $display("test_zero signed_en=%0d bcd=%h", m, bus10.bcd);
        end
    endtask

    task automatic test_hold_and_ignore();
        int lat;
        int extra_done;
        @(negedge clk);
        start = 1'b1; bin_v = 32'd12345; sen = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bus10.busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", bus10.busy); end
        bin_v = 32'd999; sen = 1'b1;
        lat = -1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            if (bus10.done) begin lat = e; break; end
        end
        start = 1'b0;
        vectors++; if (lat !== 34) begin errors++; $display("FAIL ignore_latency got %0d want 34", lat); end
        vectors++; if (bus10.bcd !== 40'h12345) begin errors++; $display("FAIL ignore_bcd got %h want 12345", bus10.bcd); end
        vectors++; if (bus10.nz_mask !== 10'h01F) begin errors++; $display("FAIL ignore_nz got %h want 01f", bus10.nz_mask); end
        vectors++; if (bus10.busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b want 0", bus10.busy); end
        extra_done = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (bus10.done || bus10.busy) extra_done++;
        end
        vectors++; if (extra_done !== 0) begin errors++; $display("FAIL no_queue got %0d busy/done cycles want 0", extra_done); end
        vectors++; if ({bus10.sign, bus10.bcd} !== {1'b0, 40'h12345}) begin errors++; $display("FAIL hold got sign=%b bcd=%h want sign=0 bcd=12345", bus10.sign, bus10.bcd); end
        $display("test_hold_and_ignore bcd=%h lat=%0d", bus10.bcd, lat);
    endtask

    task automatic test_back_to_back();
        int ndone;
        int t0;
        int t1;
        logic [39:0] r0;
        logic [39:0] r1;
        ndone = 0; t0 = -1; t1 = -1; r0 = '0; r1 = '0;
        for (int e = 0; e < 80; e++) begin
            @(negedge clk);
            if (e < 40) begin
                start = 1'b1; bin_v = 32'(1000 + e); sen = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (bus10.done) begin
                if (ndone == 0) begin t0 = e; r0 = bus10.bcd; end
                if (ndone == 1) begin t1 = e; r1 = bus10.bcd; end
                ndone++;
            end
        end
        vectors++; if (ndone !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", ndone); end
        vectors++; if (t0 !== 34 || r0 !== 40'h1000) begin errors++; $display("FAIL b2b_first got edge=%0d bcd=%h want edge=34 bcd=1000", t0, r0); end
        vectors++; if (t1 !== 69 || r1 !== 40'h1035) begin errors++; $display("FAIL b2b_second got edge=%0d bcd=%h want edge=69 bcd=1035", t1, r1); end
        $display("test_back_to_back dones=%0d at %0d,%0d bcd=%h,%h", ndone, t0, t1, r0, r1);
    endtask

    task automatic test_reset_mid();
        int ndone;
        int lat;
        ndone = 0;
        @(negedge clk);
        start = 1'b1; bin_v = 32'd999999; sen = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            rst = (e == 11);
            @(posedge clk); #1;
            if (bus10.done) ndone++;
        end
        vectors++; if (ndone !== 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", ndone); end
        vectors++; if ({bus10.busy, bus10.bcd, bus10.nz_mask} !== {1'b0, 40'h0, 10'h001}) begin errors++; $display("FAIL abort_clear got busy=%b bcd=%h nz=%h want 0/0/001", bus10.busy, bus10.bcd, bus10.nz_mask); end
        do_conv(32'd12345, 1'b0, lat);
        vectors++; if (lat !== 34 || bus10.bcd !== 40'h12345) begin errors++; $display("FAIL post_abort got lat=%0d bcd=%h want 34/12345", lat, bus10.bcd); end
        $display("test_reset_mid dones=%0d then bcd=%h lat=%0d", ndone, bus10.bcd, lat);
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_zero();
        test_hold_and_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/bin_bcd_seq.md
BIN_BCD_SEQ -- requirements
Module: bin_bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 32, binary input width in bits (legal range 4..64).
REQ-002 SHALL have parameter DIGITS, default 10, number of BCD output digits (legal range 1..20).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-high (asserted when 1).
REQ-005 SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-006 SHALL have port bin  input  BIN_W  binary operand, captured with start.
REQ-007 SHALL have port signed_en  input  1  1 = treat bin as two's complement; captured with start.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse when results update.
REQ-010 SHALL have port bcd  output  4*DIGITS  result digits; [3:0] = ones, [4*DIGITS-1:4*DIGITS-4] = most significant.
REQ-011 SHALL have port sign  output  1  1 = captured operand was negative (signed_en=1 only).
REQ-012 SHALL have port overflow  output  1  magnitude did not fit in DIGITS digits.
REQ-013 SHALL have port nz_mask  output  DIGITS  bit i = 1 if digit i or any higher digit is nonzero; bit 0 always 1 (leading-zero blanking).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE; reset state IDLE.
REQ-015 IDLE: start=1 SHALL capture bin and signed_en and go to LOAD; otherwise stay.
REQ-016 LOAD (1 cycle): magnitude = -bin (BIN_W-bit) if signed_en=1 and bin[BIN_W-1]=1, else bin; clear BCD shift register, shift counter and overflow accumulator; go to SHIFT.
REQ-017 Most negative input (e.g. 32'h80000000) SHALL yield magnitude 2^(BIN_W-1) as unsigned, with no error.
REQ-018 SHIFT: each cycle, add 3 to every 4-bit digit whose value is >= 5, then shift {BCD register, magnitude} left by one bit; exactly BIN_W cycles, then go to DONE.
REQ-019 Any 1 bit shifted out of the top digit during SHIFT SHALL set the sticky overflow accumulator.
REQ-020 On overflow, bcd SHALL equal the magnitude modulo 10^DIGITS.
REQ-021 DONE (1 cycle): register bcd, sign, overflow, nz_mask from internal state; done=1; go to IDLE.
REQ-022 Latency: done SHALL be high exactly BIN_W+2 rising edges after the edge that sampled start (34 for BIN_W=32).
REQ-023 start while busy=1 (LOAD, SHIFT, DONE) SHALL be ignored with no queuing; changes to bin or signed_en after capture SHALL have no effect.
REQ-024 Back-to-back throughput: a new start is accepted the cycle after DONE, giving one result per BIN_W+3 cycles.
REQ-025 bcd, sign, overflow, nz_mask SHALL hold their values between done pulses.
REQ-026 sign SHALL be 0 whenever signed_en=0; a zero result SHALL never report sign=1.
REQ-027 Converter SHALL use a fixed number of digit-correction adders, one per digit, shared across SHIFT cycles; no per-bit unrolled loop.

Reset
REQ-028 rst_n=1 at a rising edge SHALL force state IDLE, busy=0, done=0, bcd=0, sign=0, overflow=0, nz_mask=1 (bit 0 only).
REQ-029 Reset mid-conversion SHALL abort it without a done pulse; conversion is accepted normally after rst_n returns to 0.
REQ-030 start asserted in the same cycle as rst_n=1 SHALL be ignored.

Verification
REQ-031 BIN_W=32, DIGITS=10, unsigned 32'hFFFFFFFF -> bcd=4294967295, overflow=0, sign=0, nz_mask=10'h3FF, done at edge 34.
REQ-032 BIN_W=32, DIGITS=9, unsigned 32'hFFFFFFFF -> bcd=294967295, overflow=1.
REQ-033 signed_en=1, bin=32'hFFFFFFFF -> sign=1, bcd=1, nz_mask=10'h001; bin=32'h80000000 -> sign=1, bcd=2147483648, overflow=0.
REQ-034 bin=0 (either mode) -> bcd=0, sign=0, overflow=0, nz_mask=10'h001.
REQ-035 start=1 held for 40 cycles with a new bin every cycle -> one done per 35 cycles; each result matches the bin present at its accepted start edge.
REQ-036 rst_n=1 at SHIFT cycle 10 -> no done, outputs cleared; next start with bin=12345 -> bcd=12345 at edge 34.
